// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle: decode-stage valid/ready handshake plus the ROM address/enable/data port.
// The master modport is the fetch sequencer; the slave modport is the decode stage together with the ROM.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output instr_valid,
    output instr_data,
    output instr_pc,
    output rom_addr,
    output rom_en,
    input  instr_ready,
    input  rom_data
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    input  rom_addr,
    input  rom_en,
    output instr_ready,
    output rom_data
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM and buffers one word toward decode.
// Optional IMEM_FETCH_PERF_EN adds saturating handshake/stall counters as extra ports.
module imem_fetch_ctrl #(
  parameter int              ADDR_W    = 7,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 7'h00,
  parameter logic [ADDR_W-1:0] PROG_LAST = 7'h48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code,
`ifdef IMEM_FETCH_PERF_EN
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count,
`endif
  imem_fetch_ctrl_if.master bus
);

  // state | meaning
  // IDLE  | ROM disabled, waiting for start
  // RUN   | fetching sequentially, honouring redirects and backpressure
  // FAULT | sticky fault (misaligned redirect or PC past program end); start recovers
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_MISALIGN  = 2'd1;
  localparam logic [1:0] FC_PAST_END  = 2'd2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] raddr_q;

  logic pc_in_prog;
  logic buf_free;
  logic fetch_go;

  assign pc_in_prog = (pc_q[1:0] == 2'b00) && (pc_q <= PROG_LAST);
  assign buf_free   = !valid_q || bus.instr_ready;
  assign fetch_go   = (state_q == S_RUN) && buf_free && !redirect_valid && pc_in_prog;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          code_d  = FC_NONE;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          // A same-cycle handshake still completes: the buffer simply empties.
          valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            code_d  = FC_MISALIGN;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (buf_free) begin
          if (pc_in_prog) begin
            data_d  = bus.rom_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
          end else begin
            valid_d = 1'b0;
            state_d = S_FAULT;
            code_d  = FC_PAST_END;
          end
        end
      end
      S_FAULT: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      code_q  <= FC_NONE;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      code_q  <= code_d;
      if (fetch_go) begin
        raddr_q <= pc_q;
      end
    end
  end

  // ROM address follows the PC only while enabled, otherwise it parks on the last fetch.
  assign bus.rom_en      = fetch_go;
  assign bus.rom_addr    = fetch_go ? pc_q : raddr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_data  = data_q;
  assign bus.instr_pc    = ipc_q;
  assign busy            = (state_q == S_RUN);
  assign fault           = (state_q == S_FAULT);
  assign fault_code      = code_q;

`ifdef IMEM_FETCH_PERF_EN
  logic [15:0] fcnt_q;
  logic [15:0] scnt_q;
  logic        start_accept;

  assign start_accept = start && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n || start_accept) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (valid_q && bus.instr_ready && (fcnt_q != 16'hFFFF)) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
      if (valid_q && !bus.instr_ready && (scnt_q != 16'hFFFF)) begin
        scnt_q <= scnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: byte-wide little-endian ROM model plus an expected-delivery queue
// that is checked on every decode handshake.
module tb_imem_fetch_ctrl;
  localparam int         ADDR_W    = 7;
  localparam int         DATA_W    = 32;
  localparam logic [6:0] PROG_LAST = 7'h48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       redirect_valid;
  logic [6:0] redirect_pc;
  logic       busy;
  logic       fault;
  logic [1:0] fault_code;
`ifdef IMEM_FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  imem_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .fault          (fault),
    .fault_code     (fault_code),
`ifdef IMEM_FETCH_PERF_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] prog    [0:18];
  logic [7:0]  rom_mem [0:127];
  logic [6:0]  ra0, ra1, ra2, ra3;

  assign ra0 = bus.rom_addr;
  assign ra1 = bus.rom_addr + 7'd1;
  assign ra2 = bus.rom_addr + 7'd2;
  assign ra3 = bus.rom_addr + 7'd3;
  assign bus.rom_data = bus.rom_en ? {rom_mem[ra3], rom_mem[ra2], rom_mem[ra1], rom_mem[ra0]} : 'z;

  typedef struct packed {
    logic [6:0]  pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] a);
    sb.push_back('{pc: a, data: prog[a[6:2]]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",        32'(busy),            32'h0);
    chk("rst_fault",       32'(fault),           32'h0);
    chk("rst_fault_code",  32'(fault_code),      32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr_data",  32'(bus.instr_data),  32'h0);
    chk("rst_instr_pc",    32'(bus.instr_pc),    32'h0);
    chk("rst_rom_en",      32'(bus.rom_en),      32'h0);
    chk("rst_rom_addr",    32'(bus.rom_addr),    32'h0);
  endtask

  // Every completed decode handshake must match the oldest expected delivery.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pc", 32'(bus.instr_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr_pc",   32'(bus.instr_pc), 32'(e.pc));
        chk("sb_instr_data", bus.instr_data,    e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 7'h00;
    bus.instr_ready = 1'b0;

    prog[0]  = 32'h00450693; prog[1]  = 32'h00100713; prog[2]  = 32'h00b76463;
    prog[3]  = 32'h00e6a023; prog[4]  = 32'h0006a803; prog[5]  = 32'h00068613;
    prog[6]  = 32'h00070793; prog[7]  = 32'hffc62883; prog[8]  = 32'h0107d863;
    prog[9]  = 32'h01162023; prog[10] = 32'hffc78793; prog[11] = 32'hffc60613;
    prog[12] = 32'hfec79ae3; prog[13] = 32'h00c6a023; prog[14] = 32'h00470713;
    prog[15] = 32'hff1ff06f; prog[16] = 32'h00000013; prog[17] = 32'h00000013;
    prog[18] = 32'hfc1ff06f;
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;
    for (int w = 0; w < 19; w++)
      for (int b = 0; b < 4; b++)
        rom_mem[w*4 + b] = prog[w][8*b +: 8];

    // Reset, then idle with a redirect that must be ignored.
    repeat (2) tick();
    chk_reset_outputs();
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 7'h1C;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    chk("idle_rom_en",      32'(bus.rom_en),      32'h0);
    chk("idle_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("idle_busy",        32'(busy),            32'h0);
    chk("idle_fault",       32'(fault),           32'h0);

    // Start and stream; first word appears two edges after start.
    bus.instr_ready = 1'b1;
    push_exp(7'h00); push_exp(7'h04); push_exp(7'h08);
    push_exp(7'h0C); push_exp(7'h10); push_exp(7'h14);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",        32'(busy),            32'h1);
    chk("start_valid_early", 32'(bus.instr_valid), 32'h0);
    chk("start_rom_en",      32'(bus.rom_en),      32'h1);
    chk("start_rom_addr",    32'(bus.rom_addr),    32'h00);
    tick();
    chk("lat_valid", 32'(bus.instr_valid), 32'h1);
    chk("lat_pc",    32'(bus.instr_pc),    32'h00);
    tick(); chk("stream_pc4", 32'(bus.instr_pc), 32'h04);
    tick(); chk("stream_pc8", 32'(bus.instr_pc), 32'h08);
    tick(); chk("stream_pcC", 32'(bus.instr_pc), 32'h0C);
    tick(); chk("stream_pc10", 32'(bus.instr_pc), 32'h10);

    // Backpressure for three cycles; a start in RUN must be ignored.
    bus.instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid",  32'(bus.instr_valid), 32'h1);
      chk("bp_pc",     32'(bus.instr_pc),    32'h10);
      chk("bp_data",   bus.instr_data,       prog[4]);
      chk("bp_rom_en", 32'(bus.rom_en),      32'h0);
      if (i == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    bus.instr_ready = 1'b1;
    #1;
    chk("release_rom_en",   32'(bus.rom_en),   32'h1);
    chk("release_rom_addr", 32'(bus.rom_addr), 32'h14);
    tick();
    chk("release_pc14", 32'(bus.instr_pc), 32'h14);

    // Redirect coinciding with a handshake.
    push_exp(7'h1C);
    redirect_valid = 1'b1;
    redirect_pc    = 7'h1C;
    #1;
    chk("redir_rom_en", 32'(bus.rom_en), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_gap_valid", 32'(bus.instr_valid), 32'h0);
    chk("redir_rom_en2",   32'(bus.rom_en),      32'h1);
    chk("redir_rom_addr",  32'(bus.rom_addr),    32'h1C);
    tick();
    chk("redir_valid", 32'(bus.instr_valid), 32'h1);
    chk("redir_pc",    32'(bus.instr_pc),    32'h1C);

    // Misaligned redirect faults.
    redirect_valid = 1'b1;
    redirect_pc    = 7'h22;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault",  32'(fault),           32'h1);
    chk("mis_code",   32'(fault_code),      32'h1);
    chk("mis_valid",  32'(bus.instr_valid), 32'h0);
    chk("mis_busy",   32'(busy),            32'h0);
    chk("mis_rom_en", 32'(bus.rom_en),      32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 7'h1C;
    tick();
    redirect_valid = 1'b0;
    chk("fault_redir_ignored", 32'(fault),      32'h1);
    chk("fault_code_held",     32'(fault_code), 32'h1);

    // Restart and run sequentially off the end of the program.
    for (int a = 0; a <= 32'h48; a += 4) push_exp(7'(a));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_fault", 32'(fault),      32'h0);
    chk("restart_code",  32'(fault_code), 32'h0);
    chk("restart_busy",  32'(busy),       32'h1);
    for (int i = 0; i < 60 && fault !== 1'b1; i++) begin
      if (bus.rom_en === 1'b1) chk("rom_in_range", 32'(bus.rom_addr <= PROG_LAST), 32'h1);
      tick();
    end
    chk("end_fault",   32'(fault),           32'h1);
    chk("end_code",    32'(fault_code),      32'h2);
    chk("end_rom_en",  32'(bus.rom_en),      32'h0);
    chk("end_valid",   32'(bus.instr_valid), 32'h0);
    chk("end_sb_left", 32'(sb.size()),       32'h0);

    // Recover from the end-of-program fault, then reset mid-stream.
    push_exp(7'h00); push_exp(7'h04);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rec_fault", 32'(fault),      32'h0);
    chk("rec_code",  32'(fault_code), 32'h0);
    tick();
    chk("rec_valid", 32'(bus.instr_valid), 32'h1);
    chk("rec_pc",    32'(bus.instr_pc),    32'h00);
    chk("rec_data",  bus.instr_data,       prog[0]);
    tick();
    chk("rec_pc4",   32'(bus.instr_pc),    32'h04);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs();
    sb.delete();
    rst_n = 1'b1;
    push_exp(7'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_valid", 32'(bus.instr_valid), 32'h1);
    chk("post_rst_pc",    32'(bus.instr_pc),    32'h00);
    chk("post_rst_data",  bus.instr_data,       prog[0]);
    tick();
    bus.instr_ready = 1'b0;
    #1;
    chk("post_rst_sb_left", 32'(sb.size()), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
